// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle sequencer for the 16-bit TSC CPU with halt, retire count and memory watchdog
module multi_cycle_control #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] instr,
  input  logic                 bcond,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_source,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           wb_sel,
  output logic                 output_active,
  output logic                 is_halted,
  output logic                 err,
  output logic [WORD_SIZE-1:0] num_inst
);

  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_INIT, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  state_t state, next_state;
  logic [WD_W-1:0] wd;
  logic retire;
  logic wd_expire;

  logic [3:0] opcode;
  logic [5:0] func;
  logic is_rtype, is_ralu, is_br, is_adi, is_zimm, is_lwd, is_swd;
  logic is_jmp, is_jal, is_jpr, is_jrl, is_wwd, is_hlt, needs_ex;
  logic unused_bits;

  assign opcode      = instr[WORD_SIZE-1 -: 4];
  assign func        = instr[5:0];
  assign unused_bits = ^instr[WORD_SIZE-5:6];

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_ralu  = is_rtype && (func[5:3] == 3'd0);
  assign is_jpr   = is_rtype && (func == FN_JPR);
  assign is_jrl   = is_rtype && (func == FN_JRL);
  assign is_wwd   = is_rtype && (func == FN_WWD);
  assign is_hlt   = is_rtype && (func == FN_HLT);
  assign is_br    = (opcode[3:2] == OP_BNE[3:2]);
  assign is_adi   = (opcode == OP_ADI);
  assign is_zimm  = (opcode == OP_ORI) || (opcode == OP_LHI);
  assign is_lwd   = (opcode == OP_LWD);
  assign is_swd   = (opcode == OP_SWD);
  assign is_jmp   = (opcode == OP_JMP);
  assign is_jal   = (opcode == OP_JAL);
  assign needs_ex = is_ralu | is_br | is_adi | is_zimm | is_lwd | is_swd | is_jpr | is_jrl | is_wwd;

  // An ack arriving in the expiry cycle is checked first, so it still wins.
  assign wd_expire = (MEM_TIMEOUT != 0) && (wd == WD_LAST);

  always_comb begin
    next_state    = state;
    mem_req       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_source     = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    reg_write     = 1'b0;
    reg_dst       = 2'd0;
    wb_sel        = 2'd0;
    output_active = 1'b0;
    is_halted     = 1'b0;
    err           = 1'b0;
    case (state)
      S_INIT: next_state = S_IF;
      S_IF: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ack) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_ID;
        end else if (wd_expire) begin
          next_state = S_ERR;
        end
      end
      S_ID: begin
        alu_src_b = 2'd2;
        if (is_jmp || is_jal) begin
          pc_write   = 1'b1;
          pc_source  = 2'd2;
          next_state = S_IF;
          if (is_jal) begin
            reg_write = 1'b1;
            reg_dst   = 2'd2;
            wb_sel    = 2'd2;
          end
        end else if (is_hlt) begin
          next_state = S_HALT;
        end else if (needs_ex) begin
          next_state = S_EX;
        end else begin
          next_state = S_IF;
        end
      end
      S_EX: begin
        next_state = S_IF;
        if (is_ralu || is_br) begin
          alu_src_a = 1'b1;
          if (is_ralu) next_state = S_WB;
          if (is_br && bcond) begin
            pc_write  = 1'b1;
            pc_source = 2'd1;
          end
        end else if (is_adi || is_lwd || is_swd) begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'd2;
          next_state = is_adi ? S_WB : S_MEM;
        end else if (is_zimm) begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'd3;
          next_state = S_WB;
        end else if (is_jpr || is_jrl) begin
          pc_write  = 1'b1;
          pc_source = 2'd3;
          if (is_jrl) begin
            reg_write = 1'b1;
            reg_dst   = 2'd2;
            wb_sel    = 2'd2;
          end
        end else if (is_wwd) begin
          output_active = 1'b1;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        i_or_d    = 1'b1;
        mem_read  = is_lwd;
        mem_write = is_swd;
        if (mem_ack) next_state = is_lwd ? S_WB : S_IF;
        else if (wd_expire) next_state = S_ERR;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_ralu ? 2'd1 : 2'd0;
        wb_sel     = is_lwd ? 2'd1 : 2'd0;
        next_state = S_IF;
      end
      S_HALT: is_halted = 1'b1;
      S_ERR:  err = 1'b1;
      default: next_state = S_INIT;
    endcase
  end

  assign retire = ((state == S_ID) || (state == S_EX) || (state == S_MEM) || (state == S_WB)) &&
                  ((next_state == S_IF) || (next_state == S_HALT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_INIT;
      wd       <= '0;
      num_inst <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) wd <= '0;
      else if (((state == S_IF) || (state == S_MEM)) && !mem_ack) wd <= wd + WD_W'(1);
      if (retire) num_inst <= num_inst + WORD_SIZE'(1);
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb/tb_multi_cycle_control.sv - scoreboard bench for multi_cycle_control with an instruction-level reference model
module tb_multi_cycle_control;

  typedef struct packed {
    logic        mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0]  pc_source;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        reg_write;
    logic [1:0]  reg_dst, wb_sel;
    logic        output_active, is_halted, err;
    logic [15:0] num_inst;
  } ctl_t;

  typedef enum int {
    K_RALU, K_ADI, K_ZIMM, K_LWD, K_SWD, K_BR, K_JMP, K_JAL, K_JPR, K_JRL, K_WWD, K_NOP, K_HLT
  } kind_t;

  logic clk, reset, bcond, mem_ack;
  logic [15:0] instr;
  logic mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write, alu_src_a, reg_write;
  logic output_active, is_halted, err;
  logic [1:0] pc_source, alu_src_b, reg_dst, wb_sel;
  logic [15:0] num_inst;

  ctl_t act;
  ctl_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int model_cnt = 0;
  int cyc = 0;
  bit errored = 0;

  multi_cycle_control #(.WORD_SIZE(16), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .bcond(bcond), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .output_active(output_active), .is_halted(is_halted), .err(err), .num_inst(num_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    act = '0;
    act.mem_req = mem_req; act.mem_read = mem_read; act.mem_write = mem_write;
    act.i_or_d = i_or_d; act.ir_write = ir_write; act.pc_write = pc_write;
    act.pc_source = pc_source; act.alu_src_a = alu_src_a; act.alu_src_b = alu_src_b;
    act.reg_write = reg_write; act.reg_dst = reg_dst; act.wb_sel = wb_sel;
    act.output_active = output_active; act.is_halted = is_halted; act.err = err;
    act.num_inst = num_inst;
  end

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  initial begin
    ctl_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL ctl cycle %0d: got %h expected %h", cyc, act, e);
        end
      end
    end
  end

  function automatic ctl_t base();
    ctl_t e = '0;
    e.num_inst = 16'(model_cnt);
    return e;
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic step(input logic ack, input logic [15:0] ir, input logic bc, input ctl_t e);
    @(posedge clk);
    #1;
    mem_ack = ack; instr = ir; bcond = bc;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    model_cnt = 0;
    errored = 0;
    @(posedge clk); #1; reset = 1'b1; exp_q.push_back(base());
    @(posedge clk); #1; reset = 1'b0; exp_q.push_back(base());
  endtask

  task automatic async_reset_check(input string name);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_read, mem_write, ir_write, pc_write, reg_write, is_halted, err} !== 8'd0 ||
        num_inst !== 16'd0) begin
      errors++;
      $display("FAIL %s: got req=%b halted=%b err=%b num_inst=%0d, expected all zero",
               name, mem_req, is_halted, err, num_inst);
    end
    model_cnt = 0;
    errored = 0;
    @(posedge clk); #1; exp_q.push_back(base());
    @(posedge clk); #1; reset = 1'b0; exp_q.push_back(base());
  endtask

  // Instruction fetch waits d cycles for the ack; four unanswered cycles trip the watchdog.
  task automatic fetch(input int d);
    ctl_t e = base();
    e.mem_req = 1'b1; e.mem_read = 1'b1; e.alu_src_b = 2'd1;
    for (int i = 0; i < ((d < 4) ? d : 4); i++) step(1'b0, 16'($urandom), rbit(), e);
    if (d >= 4) begin errored = 1; return; end
    e.ir_write = 1'b1; e.pc_write = 1'b1;
    step(1'b1, 16'($urandom), rbit(), e);
  endtask

  task automatic mem_phase(input bit is_w, input logic [15:0] ir, input int d);
    ctl_t e = base();
    e.mem_req = 1'b1; e.i_or_d = 1'b1; e.mem_read = !is_w; e.mem_write = is_w;
    for (int i = 0; i < ((d < 4) ? d : 4); i++) step(1'b0, ir, rbit(), e);
    if (d >= 4) begin errored = 1; return; end
    step(1'b1, ir, rbit(), e);
  endtask

  task automatic hold(input int n, input bit halted);
    ctl_t e;
    for (int i = 0; i < n; i++) begin
      e = base();
      e.is_halted = halted; e.err = !halted;
      step(rbit(), 16'($urandom), rbit(), e);
    end
  endtask

  function automatic logic [15:0] make_instr(input kind_t k);
    logic [15:0] r = 16'($urandom);
    logic [5:0] f;
    case (k)
      K_RALU: return {4'hF, r[11:6], 6'($urandom_range(0, 7))};
      K_ADI:  return {4'h4, r[11:0]};
      K_ZIMM: return {($urandom_range(0, 1) != 0) ? 4'h6 : 4'h5, r[11:0]};
      K_LWD:  return {4'h7, r[11:0]};
      K_SWD:  return {4'h8, r[11:0]};
      K_BR:   return {4'($urandom_range(0, 3)), r[11:0]};
      K_JMP:  return {4'h9, r[11:0]};
      K_JAL:  return {4'hA, r[11:0]};
      K_JPR:  return {4'hF, r[11:6], 6'd25};
      K_JRL:  return {4'hF, r[11:6], 6'd26};
      K_WWD:  return {4'hF, r[11:6], 6'd28};
      K_HLT:  return {4'hF, r[11:6], 6'd29};
      default: begin
        if ($urandom_range(0, 1) != 0) return {4'($urandom_range(11, 14)), r[11:0]};
        f = 6'($urandom_range(8, 63));
        while (f == 6'd25 || f == 6'd26 || f == 6'd28 || f == 6'd29) f = 6'($urandom_range(8, 63));
        return {4'hF, r[11:6], f};
      end
    endcase
  endfunction

  // Reference model: the cycle-by-cycle control pattern each instruction class must produce.
  task automatic run(input kind_t k, input logic [15:0] ir, input int d_if, input int d_mem, input logic bc);
    ctl_t e;
    fetch(d_if);
    if (errored) return;
    e = base();
    e.alu_src_b = 2'd2;
    if (k == K_JMP || k == K_JAL) begin e.pc_write = 1'b1; e.pc_source = 2'd2; end
    if (k == K_JAL) begin e.reg_write = 1'b1; e.reg_dst = 2'd2; e.wb_sel = 2'd2; end
    step(rbit(), ir, rbit(), e);
    if (k inside {K_JMP, K_JAL, K_NOP, K_HLT}) begin model_cnt++; return; end

    e = base();
    case (k)
      K_RALU: e.alu_src_a = 1'b1;
      K_BR: begin
        e.alu_src_a = 1'b1;
        if (bc) begin e.pc_write = 1'b1; e.pc_source = 2'd1; end
      end
      K_ADI, K_LWD, K_SWD: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; end
      K_ZIMM: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd3; end
      K_JPR: begin e.pc_write = 1'b1; e.pc_source = 2'd3; end
      K_JRL: begin
        e.pc_write = 1'b1; e.pc_source = 2'd3;
        e.reg_write = 1'b1; e.reg_dst = 2'd2; e.wb_sel = 2'd2;
      end
      K_WWD: e.output_active = 1'b1;
      default: ;
    endcase
    step(rbit(), ir, bc, e);
    if (k inside {K_BR, K_JPR, K_JRL, K_WWD}) begin model_cnt++; return; end

    if (k == K_LWD || k == K_SWD) begin
      mem_phase(k == K_SWD, ir, d_mem);
      if (errored) return;
      if (k == K_SWD) begin model_cnt++; return; end
    end

    e = base();
    e.reg_write = 1'b1;
    e.reg_dst = (k == K_RALU) ? 2'd1 : 2'd0;
    e.wb_sel  = (k == K_LWD) ? 2'd1 : 2'd0;
    step(rbit(), ir, rbit(), e);
    model_cnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached with %0d expectations pending", exp_q.size());
    $fatal(1, "time limit");
  end

  initial begin
    kind_t k;
    ctl_t e;
    reset = 1'b1; mem_ack = 1'b0; instr = 16'd0; bcond = 1'b0;
    do_reset();

    run(K_ADI, 16'h4105, 0, 0, 1'b0);
    run(K_LWD, make_instr(K_LWD), 0, 3, 1'b0);
    run(K_BR, 16'h1403, 1, 0, 1'b1);
    run(K_BR, 16'h1403, 0, 0, 1'b0);
    run(K_JAL, 16'hA123, 2, 0, 1'b0);
    run(K_ADI, make_instr(K_ADI), 3, 0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      k = kind_t'($urandom_range(0, 11));
      run(k, make_instr(k), $urandom_range(0, 3), $urandom_range(0, 3), rbit());
    end

    run(K_HLT, make_instr(K_HLT), 1, 0, 1'b0);
    hold(6, 1'b1);
    async_reset_check("reset_in_halt");

    run(K_ADI, make_instr(K_ADI), 4, 0, 1'b0);
    hold(5, 1'b0);
    async_reset_check("reset_in_err_if");

    run(K_SWD, make_instr(K_SWD), 0, 3, 1'b0);
    run(K_LWD, make_instr(K_LWD), 1, 4, 1'b0);
    hold(4, 1'b0);
    async_reset_check("reset_in_err_mem");

    e = base();
    e.mem_req = 1'b1; e.mem_read = 1'b1; e.alu_src_b = 2'd1;
    step(1'b0, 16'($urandom), 1'b0, e);
    step(1'b0, 16'($urandom), 1'b0, e);
    async_reset_check("reset_mid_request");
    run(K_RALU, make_instr(K_RALU), 0, 0, 1'b0);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
